// File: rtl/nn_pkg.sv
// Shared types and widths for the int4 fully-connected layer sequencer.
package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int ACT_W  = 4;
    localparam int ADDR_W = 32;

endpackage

// File: rtl/nn_layer_seq.sv
// Sequencer for one fully-connected int4 layer: clears the layer, streams activations with
// matching weight addresses, waits for all neurons, then drains the snapshotted results.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_CLEAR | one-cycle accumulator clear pulse to the layer
// S_FEED  | issuing activation reads k = 0..NUM_INPUTS-1, one per cycle
// S_FLUSH | final activation/weight pair presented to the layer
// S_WAIT  | waiting for every neuron done flag, bounded by TIMEOUT
// S_DRAIN | streaming snapshotted results in neuron index order
// S_DONE  | one-cycle done pulse
module nn_layer_seq
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 128,
    parameter int TIMEOUT     = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           err_timeout,
    output logic [$clog2(NUM_INPUTS)-1:0]  in_rd_addr,
    input  logic [ACT_W-1:0]               in_rd_data,
    output logic                           layer_clr,
    output logic [ADDR_W-1:0]              local_addr,
    output logic [ACT_W-1:0]               data_in,
    output logic                           input_valid,
    input  logic [NUM_NEURONS-1:0]         out_valids,
    input  logic [NUM_NEURONS*ACT_W-1:0]   layer_out,
    output logic [ACT_W-1:0]               res_data,
    output logic [$clog2(NUM_NEURONS)-1:0] res_idx,
    output logic                           res_valid,
    input  logic                           res_ready
);

    localparam int IN_AW = $clog2(NUM_INPUTS);
    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam int K_W   = $clog2(NUM_INPUTS + 1);
    localparam int I_W   = $clog2(NUM_NEURONS + 1);
    localparam int T_W   = $clog2(TIMEOUT + 1);

    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_INPUTS - 1);
    localparam logic [I_W-1:0] I_LAST = I_W'(NUM_NEURONS - 1);
    localparam logic [T_W-1:0] T_LOAD = T_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [K_W-1:0]  k;
    logic [I_W-1:0]  idx;
    logic [T_W-1:0]  tmr;
    logic            p1;
    logic            done_q;
    logic            err_q;
    logic [ACT_W-1:0] res_buf [NUM_NEURONS];

    logic feed_last;
    logic all_valid;
    logic tmr_expired;
    logic drain_last;

    assign feed_last   = (k == K_LAST);
    assign all_valid   = &out_valids;
    assign tmr_expired = (tmr == '0);
    assign drain_last  = (idx == I_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_FEED;
            S_FEED:  if (feed_last) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (all_valid) begin
                    state_nxt = S_DRAIN;
                end else if (tmr_expired) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: if (res_ready && drain_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            k      <= '0;
            idx    <= '0;
            tmr    <= '0;
            p1     <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                res_buf[i] <= '0;
            end
        end else begin
            state  <= state_nxt;
            // p1 aligns the activation with the weight memory's registered read
            p1     <= (state == S_FEED);
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) err_q <= 1'b0;
                end
                S_CLEAR: k <= '0;
                S_FEED: begin
                    if (!feed_last) k <= k + 1'b1;
                end
                S_FLUSH: tmr <= T_LOAD;
                S_WAIT: begin
                    if (all_valid) begin
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            res_buf[i] <= layer_out[i*ACT_W +: ACT_W];
                        end
                        idx <= '0;
                    end else if (tmr_expired) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (res_ready) begin
                        idx <= idx + 1'b1;
                        if (drain_last) done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = done_q;
    assign err_timeout = err_q;
    assign layer_clr   = (state == S_CLEAR);
    assign in_rd_addr  = k[IN_AW-1:0];
    assign local_addr  = ADDR_W'(in_rd_addr);
    assign input_valid = p1;
    assign data_in     = p1 ? in_rd_data : '0;
    assign res_valid   = (state == S_DRAIN);
    // idx runs one past the last neuron after the final accept, so gate the read
    assign res_idx     = res_valid ? idx[IDX_W-1:0] : '0;
    assign res_data    = res_valid ? res_buf[res_idx] : '0;

endmodule

// File: tb/tb_nn_layer_seq.sv
// Directed scoreboard bench for nn_layer_seq with a 4-input, 3-neuron model layer.
module tb_nn_layer_seq;

    localparam int NI = 4;
    localparam int NN = 3;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [1:0]  in_rd_addr;
    logic [3:0]  in_rd_data;
    logic        layer_clr;
    logic [31:0] local_addr;
    logic [3:0]  data_in;
    logic        input_valid;
    logic [2:0]  out_valids;
    logic [11:0] layer_out;
    logic [3:0]  res_data;
    logic [1:0]  res_idx;
    logic        res_valid;
    logic        res_ready;

    nn_layer_seq #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .err_timeout(err_timeout), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
        .layer_clr(layer_clr), .local_addr(local_addr), .data_in(data_in),
        .input_valid(input_valid), .out_valids(out_valids), .layer_out(layer_out),
        .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic [3:0] data;} feed_t;
    typedef struct {logic [1:0] idx; logic [3:0] data;} res_t;

    feed_t fq[$];
    res_t  rq[$];

    int total = 0;
    int bad = 0;
    int clr_cnt = 0;
    int done_cnt = 0;
    int iv_cnt = 0;
    int acc_cnt = 0;
    logic [31:0] prev_la = '0;

    logic [3:0] abuf [NI];
    int  lay_cnt = 0;
    logic stuck = 1'b0;

    // activation buffer: 1-cycle registered read
    always @(posedge clk) in_rd_data <= abuf[in_rd_addr];

    // layer model: all neurons report done the cycle after the last input pair
    always @(posedge clk) begin
        if (layer_clr) lay_cnt <= 0;
        else if (input_valid) lay_cnt <= lay_cnt + 1;
    end
    assign out_valids = (lay_cnt >= NI) ? (stuck ? 3'b011 : 3'b111) : 3'b000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_feed();
        for (int i = 0; i < NI; i++) begin
            feed_t f;
            f.addr = i;
            f.data = abuf[i];
            fq.push_back(f);
        end
    endtask

    task automatic push_res(input logic [11:0] lo);
        for (int i = 0; i < NN; i++) begin
            res_t r;
            r.idx  = 2'(i);
            r.data = lo[i*4 +: 4];
            rq.push_back(r);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        chk(tag, {busy, done, layer_clr, input_valid, res_valid, err_timeout,
                  in_rd_addr, local_addr, data_in, res_data, res_idx}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (layer_clr === 1'b1) clr_cnt++;
        if (done === 1'b1) done_cnt++;
        if (input_valid === 1'b1) begin
            iv_cnt++;
            chk("feed_expected", fq.size() != 0, 1'b1);
            if (fq.size() != 0) begin
                feed_t f;
                f = fq.pop_front();
                chk("data_in", data_in, f.data);
                chk("local_addr_prev", prev_la, f.addr);
            end
        end
        prev_la = local_addr;
        if (res_valid === 1'b1) begin
            chk("res_expected", rq.size() != 0, 1'b1);
            if (rq.size() != 0) begin
                chk("res_idx", res_idx, rq[0].idx);
                chk("res_data", res_data, rq[0].data);
                if (res_ready) begin
                    void'(rq.pop_front());
                    acc_cnt++;
                end
            end
        end
    end

    initial begin
        int lat;
        int c0, i0, d0, a0;
        rst = 1'b0;
        start = 1'b0;
        res_ready = 1'b1;
        layer_out = '0;
        abuf[0] = 4'd1; abuf[1] = 4'd2; abuf[2] = 4'd3; abuf[3] = 4'd4;
        tick();
        tick();
        check_reset("reset_state");
        rst = 1'b1;
        tick();

        // image 1: basic feed, latency and drain with ready held high
        push_feed();
        layer_out = 12'h5A3;
        push_res(layer_out);
        c0 = clr_cnt; i0 = iv_cnt; d0 = done_cnt; a0 = acc_cnt;
        pulse_start();
        chk("clear_pulse", layer_clr, 1'b1);
        lat = 1;
        while (!res_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("latency_first_res", lat, 1 + NI + 1 + 1 + 1);
        wait_done("img1_done", 50);
        tick();
        chk("img1_done_width", done, 1'b0);
        chk("img1_clr_count", clr_cnt - c0, 1);
        chk("img1_iv_count", iv_cnt - i0, NI);
        chk("img1_done_count", done_cnt - d0, 1);
        chk("img1_accepts", acc_cnt - a0, NN);
        chk("img1_res_left", rq.size(), 0);
        chk("img1_idle", busy, 1'b0);

        // image 2: random backpressure and ignored start pulses
        abuf[0] = 4'd5; abuf[1] = 4'd6; abuf[2] = 4'd7; abuf[3] = 4'd8;
        push_feed();
        layer_out = 12'h1F7;
        push_res(layer_out);
        res_ready = 1'b0;
        c0 = clr_cnt; i0 = iv_cnt; d0 = done_cnt; a0 = acc_cnt;
        pulse_start();
        tick();
        tick();
        pulse_start();
        lat = 0;
        while (!res_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("img2_drain_reached", res_valid, 1'b1);
        tick();
        tick();
        tick();
        pulse_start();
        lat = 0;
        while (!done && lat < 200) begin
            res_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        chk("img2_done", done, 1'b1);
        res_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("img2_start_not_queued", busy, 1'b0);
        chk("img2_clr_count", clr_cnt - c0, 1);
        chk("img2_iv_count", iv_cnt - i0, NI);
        chk("img2_done_count", done_cnt - d0, 1);
        chk("img2_accepts", acc_cnt - a0, NN);
        chk("img2_res_left", rq.size(), 0);

        // image 3: layer never completes -> timeout
        stuck = 1'b1;
        push_feed();
        d0 = done_cnt; a0 = acc_cnt;
        pulse_start();
        lat = 1;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        chk("timeout_latency", lat, 1 + NI + 1 + TO + 1);
        chk("timeout_err", err_timeout, 1'b1);
        chk("timeout_idle", busy, 1'b0);
        tick();
        chk("timeout_done_width", done, 1'b0);
        chk("timeout_err_sticky", err_timeout, 1'b1);
        chk("timeout_no_results", acc_cnt - a0, 0);
        chk("timeout_done_count", done_cnt - d0, 1);

        // image 4: start clears the sticky error, full image runs
        stuck = 1'b0;
        abuf[0] = 4'd2; abuf[1] = 4'd4; abuf[2] = 4'd6; abuf[3] = 4'd8;
        push_feed();
        layer_out = 12'h3C1;
        push_res(layer_out);
        a0 = acc_cnt;
        pulse_start();
        chk("err_cleared_by_start", err_timeout, 1'b0);
        wait_done("img4_done", 50);
        chk("img4_accepts", acc_cnt - a0, NN);
        tick();

        // image 5: reset in the middle of feeding
        push_feed();
        pulse_start();
        tick();
        tick();
        tick();
        chk("abort_point_addr", local_addr, 32'd2);
        rst = 1'b0;
        tick();
        check_reset("midfeed_reset");
        rst = 1'b1;
        fq.delete();
        tick();
        chk("after_reset_idle", busy, 1'b0);

        // image 6: clean image after abort
        abuf[0] = 4'd9; abuf[1] = 4'd0; abuf[2] = 4'hF; abuf[3] = 4'd3;
        push_feed();
        layer_out = 12'hC0E;
        push_res(layer_out);
        c0 = clr_cnt; i0 = iv_cnt; a0 = acc_cnt;
        pulse_start();
        wait_done("img6_done", 50);
        tick();
        chk("img6_clr_count", clr_cnt - c0, 1);
        chk("img6_iv_count", iv_cnt - i0, NI);
        chk("img6_accepts", acc_cnt - a0, NN);
        chk("img6_feed_left", fq.size(), 0);
        chk("img6_res_left", rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
